// File: rtl/clock_gen_pkg.sv
// Shared constants for the clock_gen block: counter width, default half
// period and the legal range of the half-period parameter.
package clock_gen_pkg;

    localparam int CG_CNT_W              = 16;
    localparam int CG_DEFAULT_HALF_CYCLE = 50;
    localparam int CG_HALF_CYCLE_MIN     = 1;
    localparam int CG_HALF_CYCLE_MAX     = 65535;

endpackage : clock_gen_pkg

// File: rtl/clock_gen.sv
// clock_gen: divides the reference clock into a 50% duty generated clock
// with a half period of H reference cycles, plus rise/fall strobes and a
// count of generated rising edges.
// Optional feature macro: CLOCK_GEN_LOAD_EN adds hc_load/hc_value so the
// half period can be changed at run time; the new value takes effect at the
// next toggle so a phase is never cut short or stretched mid-way.
module clock_gen
    import clock_gen_pkg::*;
#(
    parameter int half_cycle = CG_DEFAULT_HALF_CYCLE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
`ifdef CLOCK_GEN_LOAD_EN
    input  logic                hc_load,
    input  logic [CG_CNT_W-1:0] hc_value,
`endif
    output logic                clk_out,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic [CG_CNT_W-1:0] cycle_count
);

    // Reject an unusable half period while elaborating rather than building
    // a divider that never toggles.
    if ((half_cycle < CG_HALF_CYCLE_MIN) || (half_cycle > CG_HALF_CYCLE_MAX)) begin : g_bad_half_cycle
        $error("clock_gen: half_cycle=%0d outside 1..65535", half_cycle);
    end

    localparam logic [CG_CNT_W-1:0] HC_INIT = CG_CNT_W'(half_cycle);

    logic [CG_CNT_W-1:0] r_cnt;
    logic [CG_CNT_W-1:0] r_h;
    logic                r_clk_out;
    logic                r_rise;
    logic                r_fall;
    logic [CG_CNT_W-1:0] r_cycle_count;
    logic                w_toggle;

    // Toggle on the last count of the phase; the compare always uses the
    // H that started this phase.
    assign w_toggle = en && (r_cnt == (r_h - CG_CNT_W'(1)));

    // Phase counter: wraps to 0 on toggle, holds while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_toggle) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + CG_CNT_W'(1);
        end
    end

    // Generated clock and its strobes; strobes are 0 on every non-toggle cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_out <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end else begin
            r_rise <= w_toggle && !r_clk_out;
            r_fall <= w_toggle && r_clk_out;
            if (w_toggle) begin
                r_clk_out <= ~r_clk_out;
            end
        end
    end

    // Count generated rising edges in the same edge that raises clk_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_count <= '0;
        end else if (w_toggle && !r_clk_out) begin
            r_cycle_count <= r_cycle_count + CG_CNT_W'(1);
        end
    end

`ifdef CLOCK_GEN_LOAD_EN
    logic [CG_CNT_W-1:0] r_pend;
    logic                r_pend_valid;
    logic                w_load_ok;

    // A zero half period would never toggle, so such loads are dropped.
    assign w_load_ok = hc_load && (hc_value != '0);

    // Active half period: a load landing on a toggle edge applies directly to
    // the next phase; otherwise it waits in the pending register, and a later
    // load before the toggle replaces it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h          <= HC_INIT;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
        end else if (w_load_ok) begin
            if (w_toggle) begin
                r_h          <= hc_value;
                r_pend_valid <= 1'b0;
            end else begin
                r_pend       <= hc_value;
                r_pend_valid <= 1'b1;
            end
        end else if (w_toggle && r_pend_valid) begin
            r_h          <= r_pend;
            r_pend_valid <= 1'b0;
        end
    end
`else
    // Without run-time loading the half period is fixed after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h <= HC_INIT;
        end
    end
`endif

    assign clk_out     = r_clk_out;
    assign rise_pulse  = r_rise;
    assign fall_pulse  = r_fall;
    assign cycle_count = r_cycle_count;

endmodule : clock_gen

// File: tb/tb_clock_gen.sv
// Directed bench for clock_gen: a divide-by-20 instance (H=10), a
// divide-by-2 instance (H=1) and, when CLOCK_GEN_LOAD_EN is defined, an
// H=10 instance exercising run-time half-period loads.
module tb_clock_gen;

    logic        clk = 1'b0;
    logic        rst_a, en_a, rst_b, en_b;
    logic        clk_out_a, rise_a, fall_a;
    logic [15:0] count_a;
    logic        clk_out_b, rise_b, fall_b;
    logic [15:0] count_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clock_gen #(.half_cycle(10)) u_a (
        .clk        (clk),
        .rst        (rst_a),
        .en         (en_a),
`ifdef CLOCK_GEN_LOAD_EN
        .hc_load    (1'b0),
        .hc_value   (16'd0),
`endif
        .clk_out    (clk_out_a),
        .rise_pulse (rise_a),
        .fall_pulse (fall_a),
        .cycle_count(count_a)
    );

    clock_gen #(.half_cycle(1)) u_b (
        .clk        (clk),
        .rst        (rst_b),
        .en         (en_b),
`ifdef CLOCK_GEN_LOAD_EN
        .hc_load    (1'b0),
        .hc_value   (16'd0),
`endif
        .clk_out    (clk_out_b),
        .rise_pulse (rise_b),
        .fall_pulse (fall_b),
        .cycle_count(count_b)
    );

`ifdef CLOCK_GEN_LOAD_EN
    logic        rst_c, en_c, load_c;
    logic [15:0] value_c;
    logic        clk_out_c, rise_c, fall_c;
    logic [15:0] count_c;

    clock_gen #(.half_cycle(10)) u_c (
        .clk        (clk),
        .rst        (rst_c),
        .en         (en_c),
        .hc_load    (load_c),
        .hc_value   (value_c),
        .clk_out    (clk_out_c),
        .rise_pulse (rise_c),
        .fall_pulse (fall_c),
        .cycle_count(count_c)
    );
`endif

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0;
`ifdef CLOCK_GEN_LOAD_EN
        rst_c = 1'b1; en_c = 1'b0; load_c = 1'b0; value_c = 16'd0;
`endif
        // Reset held for two edges.
        step(2);
        chk("a_rst_clk",   32'(clk_out_a), 32'd0);
        chk("a_rst_count", 32'(count_a),   32'd0);
        chk("a_rst_rise",  32'(rise_a),    32'd0);
        chk("a_rst_fall",  32'(fall_a),    32'd0);

        // H=10: first rise on the 10th enabled edge, period 20.
        rst_a = 1'b0; en_a = 1'b1;
        step(9);
        chk("a_e9_clk",    32'(clk_out_a), 32'd0);
        step(1);
        chk("a_e10_clk",   32'(clk_out_a), 32'd1);
        chk("a_e10_rise",  32'(rise_a),    32'd1);
        chk("a_e10_fall",  32'(fall_a),    32'd0);
        chk("a_e10_count", 32'(count_a),   32'd1);
        step(1);
        chk("a_e11_rise",  32'(rise_a),    32'd0);
        chk("a_e11_clk",   32'(clk_out_a), 32'd1);
        step(8);
        chk("a_e19_clk",   32'(clk_out_a), 32'd1);
        step(1);
        chk("a_e20_clk",   32'(clk_out_a), 32'd0);
        chk("a_e20_fall",  32'(fall_a),    32'd1);
        chk("a_e20_rise",  32'(rise_a),    32'd0);
        step(9);
        chk("a_e29_clk",   32'(clk_out_a), 32'd0);
        step(1);
        chk("a_e30_rise",  32'(rise_a),    32'd1);
        chk("a_e30_count", 32'(count_a),   32'd2);

        // en low for 7 cycles at cnt=4 of a high phase.
        step(4);
        en_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            chk("a_hold_strb", 32'({rise_a, fall_a}), 32'd0);
        end
        chk("a_hold_clk",   32'(clk_out_a), 32'd1);
        chk("a_hold_count", 32'(count_a),   32'd2);
        en_a = 1'b1;
        step(5);
        chk("a_resume_clk", 32'(clk_out_a), 32'd1);
        step(1);
        chk("a_resume_fal", 32'(fall_a),    32'd1);
        chk("a_resume_clk0",32'(clk_out_a), 32'd0);

        // Reset at cnt=5 with clk_out=1.
        step(10);
        chk("a_pre_count", 32'(count_a),   32'd3);
        step(5);
        chk("a_pre_clk",   32'(clk_out_a), 32'd1);
        rst_a = 1'b1;
        step(1);
        chk("a_mid_clk",   32'(clk_out_a), 32'd0);
        chk("a_mid_count", 32'(count_a),   32'd0);
        rst_a = 1'b0;
        step(9);
        chk("a_rel_clk9",  32'(clk_out_a), 32'd0);
        step(1);
        chk("a_rel_rise",  32'(rise_a),    32'd1);
        chk("a_rel_count", 32'(count_a),   32'd1);

        // H=1: toggles every cycle, strobes alternate, count every 2 cycles.
        rst_b = 1'b0; en_b = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            chk("b_clk",   32'(clk_out_b), 32'(i % 2));
            chk("b_rise",  32'(rise_b),    32'(i % 2));
            chk("b_fall",  32'(fall_b),    32'((i + 1) % 2));
            chk("b_count", 32'(count_b),   32'((i + 1) / 2));
        end
        step(1000);
        chk("b_count_long", 32'(count_b), 32'd503);

`ifdef CLOCK_GEN_LOAD_EN
        // Load 3 mid-phase, then a zero load; the current phase still ends at 10.
        rst_c = 1'b0; en_c = 1'b1;
        step(4);
        load_c = 1'b1; value_c = 16'd3;
        step(1);
        value_c = 16'd0;
        step(1);
        load_c = 1'b0;
        step(3);
        chk("c_e9_clk",   32'(clk_out_c), 32'd0);
        step(1);
        chk("c_e10_rise", 32'(rise_c),    32'd1);
        step(2);
        chk("c_h3_clk1",  32'(clk_out_c), 32'd1);
        step(1);
        chk("c_h3_fall",  32'(fall_c),    32'd1);
        step(2);
        chk("c_h3_clk0",  32'(clk_out_c), 32'd0);
        step(1);
        chk("c_h3_rise",  32'(rise_c),    32'd1);
        chk("c_h3_count", 32'(count_c),   32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_clock_gen
